simon_input_conditioner: RTL and testbench

- Front-end stage that sits directly upstream of the Simon game core.
- Takes the raw pushbutton and raw switches from the board, synchronizes and debounces them, and drives the core's inputs.
- The core's advance clock (its pclk) is driven by a single clean, fixed-width pulse generated here per button press.
- The core's level and pattern inputs are driven by debounced switch values, frozen around each pulse so they are stable at the core's clock edge.

---
 rtl/simon_io_pkg.sv | 23 ++
 rtl/simon_debounce.sv | 72 +++++++
 rtl/simon_input_conditioner.sv | 144 ++++++++++++++
 tb/tb_simon_input_conditioner.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_io_pkg.sv
`default_nettype none
// ============================================================================
// Module  : simon_io_pkg
// Purpose : Shared constants for the Simon input front-end and the board top:
//           pulse FSM state encoding and default debounce / pulse timings.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package simon_io_pkg;

  // Default timings; the board top overrides DEBOUNCE_CYCLES for real buttons.
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int CNT_W_DEF           = 20;
  localparam int PULSE_CYCLES_DEF    = 2;

  // Pulse FSM state encoding.
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HIGH     = 2'd1;
  localparam logic [1:0] S_GUARD    = 2'd2;
  localparam logic [1:0] S_WAIT_REL = 2'd3;

endpackage : simon_io_pkg
`default_nettype wire

// File: rtl/simon_debounce.sv
`default_nettype none
// ============================================================================
// Module  : simon_debounce
// Purpose : Two-flop synchronizer plus bus-wide debouncer. A new value is
//           accepted only after the synchronized bus has been held identical
//           for DEBOUNCE_CYCLES cycles. While hold is high a ready commit is
//           parked (counter saturated) and lands on the first cycle hold drops.
// Ports   : clk  - clock
//           rst  - asynchronous reset, active low
//           hold - inhibit commits of a new debounced value
//           raw  - raw asynchronous input bus [W]
//           db   - debounced output bus [W]
// Revision: 1.0  initial release
// ============================================================================
module simon_debounce
  import simon_io_pkg::*;
#(
  parameter int W               = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     s1_q, s2_q;
  logic [W-1:0]     db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (s1_q != s2_q) begin
      // s2 changes on this edge: the bus was not held identical, restart.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Counter stays saturated while held so the commit lands as soon as
      // hold is released.
      if (!hold) begin
        db_d  = s2_q;
        cnt_d = '0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      db_q  <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db = db_q;

endmodule : simon_debounce
`default_nettype wire

// File: rtl/simon_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : simon_input_conditioner
// Purpose : Front end of the Simon game core. Debounces the advance button
//           into one fixed-width pclk pulse per press, and debounces the
//           level/pattern switches, freezing them while the pulse is high so
//           the core samples stable values at its clock edge.
// Ports   : clk         - board clock
//           rst         - asynchronous reset, active low
//           btn_raw     - raw advance pushbutton
//           level_raw   - raw level switch
//           pattern_raw - raw pattern switches [PATTERN_W]
//           pclk_out    - registered advance pulse to the core's pclk
//           level_out   - debounced level
//           pattern_out - debounced pattern [PATTERN_W]
//           busy        - pulse FSM not idle
// Revision: 1.0  initial release
// ============================================================================
module simon_input_conditioner
  import simon_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int PULSE_CYCLES    = PULSE_CYCLES_DEF,
  parameter int PATTERN_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_raw,
  input  logic                 level_raw,
  input  logic [PATTERN_W-1:0] pattern_raw,
  output logic                 pclk_out,
  output logic                 level_out,
  output logic [PATTERN_W-1:0] pattern_out,
  output logic                 busy
);

  localparam int              PCNT_W    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CYCLES - 1);

  logic               db_btn;
  logic [PATTERN_W:0] db_sw;
  logic               sw_hold;

  logic [1:0]        state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              pclk_q, pclk_d;
  logic              busy_q;
  logic              db_btn_prev_q;

  // Switch commits are parked while the pulse is high so the core never sees
  // level/pattern move under its clock edge.
  assign sw_hold = (state_q == S_HIGH);

  simon_debounce #(
    .W               (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_btn (
    .clk  (clk),
    .rst  (rst),
    .hold (1'b0),
    .raw  (btn_raw),
    .db   (db_btn)
  );

  simon_debounce #(
    .W               (PATTERN_W + 1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_sw (
    .clk  (clk),
    .rst  (rst),
    .hold (sw_hold),
    .raw  ({level_raw, pattern_raw}),
    .db   (db_sw)
  );

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    pclk_d  = pclk_q;
    case (state_q)
      S_IDLE: begin
        // Registered rising-edge detect: one pulse per debounced press.
        if (db_btn && !db_btn_prev_q) begin
          state_d = S_HIGH;
          pclk_d  = 1'b1;
          pcnt_d  = '0;
        end
      end
      S_HIGH: begin
        if (pcnt_q == PCNT_LAST) begin
          state_d = S_GUARD;
          pclk_d  = 1'b0;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_GUARD: begin
        if (pcnt_q == PCNT_LAST) begin
          state_d = S_WAIT_REL;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_WAIT_REL: begin
        if (!db_btn) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        pclk_d  = 1'b0;
        pcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pcnt_q        <= '0;
      pclk_q        <= 1'b0;
      busy_q        <= 1'b0;
      db_btn_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      pclk_q        <= pclk_d;
      busy_q        <= (state_d != S_IDLE);
      db_btn_prev_q <= db_btn;
    end
  end

  assign pclk_out    = pclk_q;
  assign busy        = busy_q;
  assign level_out   = db_sw[PATTERN_W];
  assign pattern_out = db_sw[PATTERN_W-1:0];

endmodule : simon_input_conditioner
`default_nettype wire

// File: tb/tb_simon_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_simon_input_conditioner
// Purpose : Self-checking bench for simon_input_conditioner with directed
//           scenarios and a randomized run against a run-length based model.
// Revision: 1.0  initial release
// ============================================================================
module tb_simon_input_conditioner;

  localparam int D  = 4;
  localparam int P  = 2;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn_raw = 1'b0;
  logic          level_raw = 1'b0;
  logic [PW-1:0] pattern_raw = '0;
  logic          pclk_out;
  logic          level_out;
  logic [PW-1:0] pattern_out;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simon_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (20),
    .PULSE_CYCLES    (P),
    .PATTERN_W       (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .level_raw   (level_raw),
    .pattern_raw (pattern_raw),
    .pclk_out    (pclk_out),
    .level_out   (level_out),
    .pattern_out (pattern_out),
    .busy        (busy)
  );

  // --------------------------------------------------------------------------
  // Reference model: a value is accepted once the raw samples have shown it
  // for D+1 consecutive clocks (switches: not while the pulse is high). A
  // pulse is a time window: P cycles high, P cycles guard, then wait for
  // the debounced button to be released.
  // --------------------------------------------------------------------------
  logic        m_db_btn, m_db_prev, m_last_btn;
  logic [PW:0] m_db_b, m_last_b;
  int          m_run_btn, m_run_b, m_edge, m_pstart;
  bit          m_active;

  task automatic model_reset();
    m_db_btn  = 1'b0;
    m_db_prev = 1'b0;
    m_last_btn = 1'b0;
    m_db_b    = '0;
    m_last_b  = '0;
    m_run_btn = 0;
    m_run_b   = 0;
    m_edge    = 0;
    m_pstart  = 0;
    m_active  = 1'b0;
  endtask

  task automatic model_step();
    int          n;
    bit          in_high;
    logic        nb;
    logic [PW:0] nbus;
    logic [PW:0] bus_now;
    n       = m_edge + 1;
    in_high = m_active && ((n - 1 - m_pstart) < P);
    nb = m_db_btn;
    if (m_last_btn != m_db_btn && m_run_btn >= D + 1) nb = m_last_btn;
    nbus = m_db_b;
    if (!in_high && m_last_b != m_db_b && m_run_b >= D + 1) nbus = m_last_b;
    if (!m_active) begin
      if (m_db_btn && !m_db_prev) begin
        m_active = 1'b1;
        m_pstart = n;
      end
    end else if ((n - 1 - m_pstart) >= 2 * P && !m_db_btn) begin
      m_active = 1'b0;
    end
    m_db_prev = m_db_btn;
    m_db_btn  = nb;
    m_db_b    = nbus;
    if (btn_raw === m_last_btn) m_run_btn = (m_run_btn < 1000) ? m_run_btn + 1 : m_run_btn;
    else m_run_btn = 1;
    m_last_btn = btn_raw;
    bus_now = {level_raw, pattern_raw};
    if (bus_now === m_last_b) m_run_b = (m_run_b < 1000) ? m_run_b + 1 : m_run_b;
    else m_run_b = 1;
    m_last_b = bus_now;
    m_edge   = n;
  endtask

  function automatic logic m_pclk();
    return m_active && ((m_edge - m_pstart) < P);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    int  pulses;
    logic prev;
    logic [PW-1:0] exp_pat;
    logic exp_pclk;
    pulses = 0;
    prev   = 1'b0;
    rst = 1'b0; btn_raw = 1'b1; pattern_raw = 4'b1111; level_raw = 1'b0;
    idle(3);
    n_vec++; if (pclk_out !== 1'b0) begin n_err++; $display("FAIL reset_pclk: got %b expected 0", pclk_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (level_out !== 1'b0) begin n_err++; $display("FAIL reset_level: got %b expected 0", level_out); end
    n_vec++; if (pattern_out !== 4'b0000) begin n_err++; $display("FAIL reset_pattern: got %b expected 0000", pattern_out); end
    rst = 1'b1;
    for (int e = 0; e < 16; e++) begin
      @(posedge clk); @(negedge clk);
      exp_pat  = (e >= 5) ? 4'b1111 : 4'b0000;
      exp_pclk = (e == 6 || e == 7);
      n_vec++; if (pattern_out !== exp_pat) begin n_err++; $display("FAIL rel_pattern e=%0d: got %b expected %b", e, pattern_out, exp_pat); end
      n_vec++; if (pclk_out !== exp_pclk) begin n_err++; $display("FAIL rel_pclk e=%0d: got %b expected %b", e, pclk_out, exp_pclk); end
      if (pclk_out && !prev) pulses++;
      prev = pclk_out;
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL rel_pulse_count: got %0d expected 1", pulses); end
    btn_raw = 1'b0;
    idle(15);
  endtask

  task automatic test_clean_press();
    int   pulses;
    logic prev;
    logic exp_pclk;
    pulses = 0;
    prev   = 1'b0;
    btn_raw = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); @(negedge clk);
      exp_pclk = (e == 6 || e == 7);
      n_vec++; if (pclk_out !== exp_pclk) begin n_err++; $display("FAIL press_pclk e=%0d: got %b expected %b", e, pclk_out, exp_pclk); end
      n_vec++; if (busy !== (e >= 6)) begin n_err++; $display("FAIL press_busy e=%0d: got %b expected %b", e, busy, (e >= 6)); end
      if (pclk_out && !prev) pulses++;
      prev = pclk_out;
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL press_pulse_count: got %0d expected 1", pulses); end
    btn_raw = 1'b0;
    for (int f = 0; f < 10; f++) begin
      @(posedge clk); @(negedge clk);
      n_vec++; if (busy !== (f < 6)) begin n_err++; $display("FAIL release_busy f=%0d: got %b expected %b", f, busy, (f < 6)); end
    end
  endtask

  task automatic test_bounce();
    int   pulses;
    logic prev;
    logic exp_pclk;
    pulses = 0;
    prev   = 1'b0;
    for (int e = 0; e < 40; e++) begin
      btn_raw = (e < 8) ? (((e / 2) % 2) == 0) : 1'b1;
      @(posedge clk); @(negedge clk);
      exp_pclk = (e == 14 || e == 15);
      n_vec++; if (pclk_out !== exp_pclk) begin n_err++; $display("FAIL bounce_pclk e=%0d: got %b expected %b", e, pclk_out, exp_pclk); end
      if (pclk_out && !prev) pulses++;
      prev = pclk_out;
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL bounce_pulse_count: got %0d expected 1", pulses); end
    btn_raw = 1'b0;
    idle(15);
  endtask

  task automatic test_switch_glitch();
    logic [PW-1:0] exp_pat;
    pattern_raw = 4'b0000;
    idle(10);
    n_vec++; if (pattern_out !== 4'b0000) begin n_err++; $display("FAIL glitch_pre: got %b expected 0000", pattern_out); end
    for (int e = 0; e < 20; e++) begin
      pattern_raw = (e < 3) ? 4'b1010 : 4'b0000;
      @(posedge clk); @(negedge clk);
      n_vec++; if (pattern_out !== 4'b0000) begin n_err++; $display("FAIL glitch_hold e=%0d: got %b expected 0000", e, pattern_out); end
    end
    for (int e = 0; e < 10; e++) begin
      pattern_raw = 4'b0001;
      @(posedge clk); @(negedge clk);
      exp_pat = (e >= 5) ? 4'b0001 : 4'b0000;
      n_vec++; if (pattern_out !== exp_pat) begin n_err++; $display("FAIL glitch_accept e=%0d: got %b expected %b", e, pattern_out, exp_pat); end
    end
  endtask

  task automatic test_freeze();
    logic [PW-1:0] exp_pat;
    logic exp_pclk;
    for (int e = 0; e < 16; e++) begin
      btn_raw     = 1'b1;
      pattern_raw = (e >= 2) ? 4'b0110 : 4'b0001;
      @(posedge clk); @(negedge clk);
      exp_pclk = (e == 6 || e == 7);
      exp_pat  = (e >= 9) ? 4'b0110 : 4'b0001;
      n_vec++; if (pclk_out !== exp_pclk) begin n_err++; $display("FAIL freeze_pclk e=%0d: got %b expected %b", e, pclk_out, exp_pclk); end
      n_vec++; if (pattern_out !== exp_pat) begin n_err++; $display("FAIL freeze_pattern e=%0d: got %b expected %b", e, pattern_out, exp_pat); end
    end
    btn_raw = 1'b0;
    idle(15);
  endtask

  task automatic test_reset_mid_pulse();
    int   pulses;
    logic prev;
    logic exp_pclk;
    for (int e = 0; e < 7; e++) begin
      btn_raw = 1'b1;
      @(posedge clk); @(negedge clk);
      exp_pclk = (e == 6);
      n_vec++; if (pclk_out !== exp_pclk) begin n_err++; $display("FAIL midrst_pre e=%0d: got %b expected %b", e, pclk_out, exp_pclk); end
    end
    #2 rst = 1'b0;
    #1;
    n_vec++; if (pclk_out !== 1'b0) begin n_err++; $display("FAIL midrst_pclk: got %b expected 0", pclk_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_vec++; if (pattern_out !== 4'b0000) begin n_err++; $display("FAIL midrst_pattern: got %b expected 0000", pattern_out); end
    @(negedge clk);
    rst = 1'b1;
    btn_raw = 1'b0;
    idle(3);
    pulses = 0;
    prev   = 1'b0;
    for (int e = 0; e < 16; e++) begin
      btn_raw = 1'b1;
      @(posedge clk); @(negedge clk);
      exp_pclk = (e == 6 || e == 7);
      n_vec++; if (pclk_out !== exp_pclk) begin n_err++; $display("FAIL repress_pclk e=%0d: got %b expected %b", e, pclk_out, exp_pclk); end
      if (pclk_out && !prev) pulses++;
      prev = pclk_out;
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL repress_pulse_count: got %0d expected 1", pulses); end
    btn_raw = 1'b0;
    idle(15);
  endtask

  task automatic test_random();
    int brun;
    int prun;
    brun = 0;
    prun = 0;
    for (int c = 0; c < 800; c++) begin
      if (brun == 0) begin
        btn_raw = 1'($urandom_range(0, 1));
        brun    = int'($urandom_range(1, 12));
      end
      if (prun == 0) begin
        {level_raw, pattern_raw} = 5'($urandom);
        prun = int'($urandom_range(1, 9));
      end
      brun--;
      prun--;
      @(posedge clk); @(negedge clk);
      n_vec++; if (pclk_out !== m_pclk()) begin n_err++; $display("FAIL rand_pclk c=%0d: got %b expected %b", c, pclk_out, m_pclk()); end
      n_vec++; if (busy !== m_active) begin n_err++; $display("FAIL rand_busy c=%0d: got %b expected %b", c, busy, m_active); end
      n_vec++; if (level_out !== m_db_b[PW]) begin n_err++; $display("FAIL rand_level c=%0d: got %b expected %b", c, level_out, m_db_b[PW]); end
      n_vec++; if (pattern_out !== m_db_b[PW-1:0]) begin n_err++; $display("FAIL rand_pattern c=%0d: got %b expected %b", c, pattern_out, m_db_b[PW-1:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_switch_glitch();
    test_freeze();
    test_reset_mid_pulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_simon_input_conditioner
`default_nettype wire
